// File: rtl/traffic_light_monitor_pkg.sv
// Shared light encodings, approach directions, monitor states and error-bit positions
// for the traffic light monitor.
package traffic_pkg;

  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_S = 2'd1;
  localparam logic [1:0] DIR_E = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } mon_state_t;

  localparam int ERR_ENC  = 0;
  localparam int ERR_CONF = 1;
  localparam int ERR_SEQ  = 2;
  localparam int ERR_TIME = 3;

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Four-approach light bus from the traffic controller: one sample strobe plus the
// n/s/e/w light codes. The controller drives it; the monitor only listens.
interface traffic_light_monitor_if;
  logic       sample_en;
  logic [2:0] n_lights;
  logic [2:0] s_lights;
  logic [2:0] e_lights;
  logic [2:0] w_lights;

  modport master (output sample_en, n_lights, s_lights, e_lights, w_lights);
  modport slave  (input  sample_en, n_lights, s_lights, e_lights, w_lights);
endinterface

// File: rtl/traffic_light_monitor_decode.sv
// Combinational decode of one approach's 3-bit light code into one-hot flags;
// anything outside the three legal codes is reported as illegal.
module traffic_light_decode
  import traffic_pkg::*;
(
  input  logic [2:0] i_lights,
  output logic       o_is_green,
  output logic       o_is_yellow,
  output logic       o_is_red,
  output logic       o_illegal
);

  assign o_is_green  = (i_lights == LIGHT_GREEN);
  assign o_is_yellow = (i_lights == LIGHT_YELLOW);
  assign o_is_red    = (i_lights == LIGHT_RED);
  assign o_illegal   = !(o_is_green || o_is_yellow || o_is_red);

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive observer of the controller's light buses: locks onto the N->S->E->W rotation,
// checks encoding, exclusion, order and dwell times, and keeps sticky error flags.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 4,
  parameter int CNT_W        = 4
) (
  input  logic                    clk,
  input  logic                    rst_a,
  traffic_light_monitor_if.slave  lights,
  input  logic                    clear_err,
  output logic                    locked,
  output logic [1:0]              cur_dir,
  output logic                    cur_phase,
  output logic [CNT_W-1:0]        dwell,
  output logic [15:0]             rotations,
  output logic [3:0]              err_flags,
  output logic                    err_pulse
);

  localparam logic [CNT_W-1:0] G_LEN = CNT_W'(GREEN_TICKS);
  localparam logic [CNT_W-1:0] Y_LEN = CNT_W'(YELLOW_TICKS);

  // Per-approach flags, indexed by direction code (bit 0 = N ... bit 3 = W).
  logic [3:0] w_green, w_yellow, w_red, w_illegal;

  traffic_light_decode u_dec_n (.i_lights(lights.n_lights), .o_is_green(w_green[0]),
    .o_is_yellow(w_yellow[0]), .o_is_red(w_red[0]), .o_illegal(w_illegal[0]));
  traffic_light_decode u_dec_s (.i_lights(lights.s_lights), .o_is_green(w_green[1]),
    .o_is_yellow(w_yellow[1]), .o_is_red(w_red[1]), .o_illegal(w_illegal[1]));
  traffic_light_decode u_dec_e (.i_lights(lights.e_lights), .o_is_green(w_green[2]),
    .o_is_yellow(w_yellow[2]), .o_is_red(w_red[2]), .o_illegal(w_illegal[2]));
  traffic_light_decode u_dec_w (.i_lights(lights.w_lights), .o_is_green(w_green[3]),
    .o_is_yellow(w_yellow[3]), .o_is_red(w_red[3]), .o_illegal(w_illegal[3]));

  mon_state_t       r_state;
  logic             r_locked;
  logic [1:0]       r_dir;
  logic             r_phase;
  logic [CNT_W-1:0] r_dwell;
  logic [15:0]      r_rot;
  logic [3:0]       r_err_flags;
  logic             r_err_pulse;

  logic [3:0]       w_nonred;
  logic             w_enc_err;
  logic             w_conf_err;
  logic             w_any_err;
  logic [1:0]       w_dir_nxt;
  logic             w_cur_g;
  logic             w_cur_y;
  logic             w_nxt_g;
  logic [1:0]       w_hunt_dir;
  logic [CNT_W-1:0] w_dwell_inc;
  logic [3:0]       w_new_err;

  always_comb begin
    w_nonred    = ~w_red;
    w_enc_err   = |w_illegal;
    // More than one bit set in the non-red vector means two approaches are open.
    w_conf_err  = !w_enc_err && ((w_nonred & (w_nonred - 4'd1)) != 4'd0);
    w_any_err   = w_enc_err || w_conf_err;
    w_dir_nxt   = r_dir + 2'd1;
    w_cur_g     = w_green[r_dir];
    w_cur_y     = w_yellow[r_dir];
    w_nxt_g     = w_green[w_dir_nxt];
    w_dwell_inc = (r_dwell == '1) ? r_dwell : r_dwell + CNT_W'(1);
    w_hunt_dir  = DIR_N;
    for (int i = 0; i < 4; i++) begin
      if (w_green[i]) w_hunt_dir = 2'(i);
    end

    w_new_err = 4'b0000;
    if (w_enc_err) begin
      w_new_err[ERR_ENC] = 1'b1;
    end else if (w_conf_err) begin
      w_new_err[ERR_CONF] = 1'b1;
    end else begin
      case (r_state)
        GREEN: begin
          // Dwell only passes through GREEN_TICKS once per phase, so overrun flags once.
          if (w_cur_g)      w_new_err[ERR_TIME] = (r_dwell == G_LEN);
          else if (w_cur_y) w_new_err[ERR_TIME] = (r_dwell != G_LEN);
          else              w_new_err[ERR_SEQ]  = 1'b1;
        end
        YELLOW: begin
          if (w_cur_y)      w_new_err[ERR_TIME] = (r_dwell == Y_LEN);
          else if (w_nxt_g) w_new_err[ERR_TIME] = (r_dwell != Y_LEN);
          else              w_new_err[ERR_SEQ]  = 1'b1;
        end
        default: ;
      endcase
    end
    if (!lights.sample_en) w_new_err = 4'b0000;
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      r_state     <= HUNT;
      r_locked    <= 1'b0;
      r_dir       <= DIR_N;
      r_phase     <= 1'b0;
      r_dwell     <= '0;
      r_rot       <= 16'd0;
      r_err_flags <= 4'b0000;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= |w_new_err;
      r_err_flags <= (clear_err ? 4'b0000 : r_err_flags) | w_new_err;
      if (lights.sample_en) begin
        if (w_any_err) begin
          r_state  <= HUNT;
          r_locked <= 1'b0;
          r_phase  <= 1'b0;
          r_dwell  <= '0;
        end else begin
          case (r_state)
            HUNT: begin
              if (|w_green) begin
                r_state  <= GREEN;
                r_locked <= 1'b1;
                r_dir    <= w_hunt_dir;
                r_phase  <= 1'b0;
                r_dwell  <= CNT_W'(1);
              end
            end
            GREEN: begin
              if (w_cur_g) begin
                r_dwell <= w_dwell_inc;
              end else if (w_cur_y) begin
                r_state <= YELLOW;
                r_phase <= 1'b1;
                r_dwell <= CNT_W'(1);
              end else begin
                r_state  <= HUNT;
                r_locked <= 1'b0;
                r_phase  <= 1'b0;
                r_dwell  <= '0;
              end
            end
            YELLOW: begin
              if (w_cur_y) begin
                r_dwell <= w_dwell_inc;
              end else if (w_nxt_g) begin
                r_state <= GREEN;
                r_dir   <= w_dir_nxt;
                r_phase <= 1'b0;
                r_dwell <= CNT_W'(1);
                if (w_dir_nxt == DIR_N && r_rot != 16'hFFFF) r_rot <= r_rot + 16'd1;
              end else begin
                r_state  <= HUNT;
                r_locked <= 1'b0;
                r_phase  <= 1'b0;
                r_dwell  <= '0;
              end
            end
            default: begin
              r_state  <= HUNT;
              r_locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign locked    = r_locked;
  assign cur_dir   = r_dir;
  assign cur_phase = r_phase;
  assign dwell     = r_dwell;
  assign rotations = r_rot;
  assign err_flags = r_err_flags;
  assign err_pulse = r_err_pulse;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: legal rotations, dwell, conflict, encoding,
// order and reset cases, each checked against hand-derived values.
module tb_traffic_light_monitor;

  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] RED = 3'b100;

  logic        clk = 1'b0;
  logic        rst_a;
  logic        clear_err;
  logic        locked;
  logic [1:0]  cur_dir;
  logic        cur_phase;
  logic [3:0]  dwell;
  logic [15:0] rotations;
  logic [3:0]  err_flags;
  logic        err_pulse;

  int n_assert = 0;
  int n_fail   = 0;

  traffic_light_monitor_if lif ();

  traffic_light_monitor #(.GREEN_TICKS(8), .YELLOW_TICKS(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_a     (rst_a),
    .lights    (lif),
    .clear_err (clear_err),
    .locked    (locked),
    .cur_dir   (cur_dir),
    .cur_phase (cur_phase),
    .dwell     (dwell),
    .rotations (rotations),
    .err_flags (err_flags),
    .err_pulse (err_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] n, input logic [2:0] s, input logic [2:0] e,
                      input logic [2:0] w);
    lif.n_lights  = n;
    lif.s_lights  = s;
    lif.e_lights  = e;
    lif.w_lights  = w;
    lif.sample_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int d, input logic [2:0] c);
    step((d == 0) ? c : RED, (d == 1) ? c : RED, (d == 2) ? c : RED, (d == 3) ? c : RED);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_dir"}, cur_dir, 0);
    chk({tag, "_phase"}, cur_phase, 0);
    chk({tag, "_dwell"}, dwell, 0);
    chk({tag, "_rot"}, rotations, 0);
    chk({tag, "_flags"}, err_flags, 0);
    chk({tag, "_pulse"}, err_pulse, 0);
  endtask

  initial begin
    rst_a         = 1'b1;
    clear_err     = 1'b0;
    lif.sample_en = 1'b0;
    lif.n_lights  = RED;
    lif.s_lights  = RED;
    lif.e_lights  = RED;
    lif.w_lights  = RED;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_a = 1'b0;

    // All red while hunting: no lock, no error.
    step(RED, RED, RED, RED);
    chk("hunt_allred_locked", locked, 0);
    chk("hunt_allred_flags", err_flags, 0);

    // Two full legal rotations.
    for (int r = 0; r < 2; r++) begin
      for (int d = 0; d < 4; d++) begin
        go(d, GRN);
        chk("legal_first_green_locked", locked, 1);
        chk("legal_first_green_dir", cur_dir, d);
        chk("legal_first_green_dwell", dwell, 1);
        if (d == 0) chk("legal_rotations", rotations, r);
        for (int k = 1; k < 8; k++) go(d, GRN);
        chk("legal_green_dwell", dwell, 8);
        for (int k = 0; k < 4; k++) go(d, YEL);
        chk("legal_yellow_phase", cur_phase, 1);
        chk("legal_yellow_dwell", dwell, 4);
        chk("legal_flags", err_flags, 0);
      end
    end

    // Idle cycles with garbage on the bus must not disturb anything.
    lif.sample_en = 1'b0;
    lif.n_lights  = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_dwell", dwell, 4);
    chk("hold_dir", cur_dir, 3);
    chk("hold_flags", err_flags, 0);
    chk("hold_locked", locked, 1);

    // Short green on N: timing error on the yellow transition.
    go(0, GRN);
    chk("wrap_rotations", rotations, 2);
    for (int k = 1; k < 7; k++) go(0, GRN);
    chk("short_green_dwell", dwell, 7);
    go(0, YEL);
    chk("short_green_flags", err_flags, 4'b1000);
    chk("short_green_pulse", err_pulse, 1);
    chk("short_green_phase", cur_phase, 1);
    chk("short_green_dir", cur_dir, 0);
    chk("short_green_locked", locked, 1);
    go(0, YEL);
    chk("short_green_pulse_drop", err_pulse, 0);
    chk("short_green_sticky", err_flags, 4'b1000);

    // Conflict while S is yellow.
    go(0, YEL);
    go(0, YEL);
    for (int k = 0; k < 8; k++) go(1, GRN);
    go(1, YEL);
    go(1, YEL);
    chk("pre_conflict_flags", err_flags, 4'b1000);
    step(GRN, YEL, RED, RED);
    chk("conflict_flags", err_flags, 4'b1010);
    chk("conflict_locked", locked, 0);
    chk("conflict_pulse", err_pulse, 1);
    step(RED, RED, RED, RED);
    chk("relock_allred", locked, 0);
    go(2, GRN);
    chk("relock_locked", locked, 1);
    chk("relock_dir", cur_dir, 2);
    chk("relock_pulse", err_pulse, 0);

    // Illegal encoding, then clear racing a new error, then a plain clear.
    for (int k = 0; k < 4; k++) go(2, GRN);
    step(RED, RED, 3'b011, RED);
    chk("enc_flags", err_flags, 4'b1011);
    chk("enc_locked", locked, 0);
    clear_err = 1'b1;
    step(RED, RED, RED, 3'b000);
    chk("clear_with_enc_flags", err_flags, 4'b0001);
    chk("clear_with_enc_pulse", err_pulse, 1);
    lif.sample_en = 1'b0;
    @(posedge clk);
    #1;
    chk("clear_flags", err_flags, 4'b0000);
    chk("clear_pulse", err_pulse, 0);
    clear_err = 1'b0;

    // N yellow followed by E green: order violation.
    for (int k = 0; k < 8; k++) go(0, GRN);
    for (int k = 0; k < 4; k++) go(0, YEL);
    chk("skip_pre_rot", rotations, 2);
    go(2, GRN);
    chk("skip_flags", err_flags, 4'b0100);
    chk("skip_locked", locked, 0);
    chk("skip_rot", rotations, 2);
    chk("skip_pulse", err_pulse, 1);

    // Asynchronous reset in the middle of an E green.
    for (int k = 0; k < 5; k++) go(2, GRN);
    chk("pre_rst_dwell", dwell, 5);
    chk("pre_rst_dir", cur_dir, 2);
    lif.sample_en = 1'b0;
    #2;
    rst_a = 1'b1;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    go(2, YEL);
    chk("post_rst_yellow_locked", locked, 0);
    step(RED, RED, RED, RED);
    chk("post_rst_red_locked", locked, 0);
    go(1, GRN);
    chk("post_rst_green_locked", locked, 1);
    chk("post_rst_green_dir", cur_dir, 1);

    // Green overrun: flagged on the ninth sample only, dwell keeps counting.
    for (int k = 1; k < 8; k++) go(1, GRN);
    chk("overrun_pre_flags", err_flags, 0);
    go(1, GRN);
    chk("overrun_flags", err_flags, 4'b1000);
    chk("overrun_pulse", err_pulse, 1);
    chk("overrun_dwell", dwell, 9);
    go(1, GRN);
    chk("overrun_once_pulse", err_pulse, 0);
    chk("overrun_dwell2", dwell, 10);
    go(1, YEL);
    chk("overrun_yellow_pulse", err_pulse, 1);
    chk("overrun_yellow_phase", cur_phase, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
